// File: rtl/lc3b_types.sv
// Shared types for the victim cache.
//
// Contents:
//   vc_state_t - controller state: IDLE (accepting requests) or WRITEBACK
//                (waiting for memory to take a dirty line).
//   vc_entry_t - per-entry status flags.
//
// Tag and data widths are parameters of param_victim_cache. A package cannot
// carry module parameters, so this struct holds only the width-independent
// fields. Tag and data live in parallel arrays in the top module, and age
// lives in vc_lru.
package lc3b_types;

    typedef enum logic {
        IDLE      = 1'b0,
        WRITEBACK = 1'b1
    } vc_state_t;

    typedef struct packed {
        logic valid;
        logic dirty;
    } vc_entry_t;

endpackage

// File: rtl/vc_lru.sv
// Age-based replacement state for the victim cache.
//
// Ports:
//   clk, rst    - clock and synchronous active-high reset. Reset sets age[i] = i.
//   touch       - an entry is being installed this cycle.
//   touch_idx   - index of the entry being installed; it becomes MRU (age 0).
//   touch_fill  - the installed slot was invalid. Every valid entry ages by
//                 one. Otherwise only entries younger than the slot's old age
//                 are aged.
//   valid_mask  - current valid bits, used for the fill aging rule.
//   oldest_idx  - entry with the largest age (lowest index on ties).
module vc_lru #(
    parameter int NUM_ENTRIES = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           touch,
    input  logic [$clog2(NUM_ENTRIES)-1:0] touch_idx,
    input  logic                           touch_fill,
    input  logic [NUM_ENTRIES-1:0]         valid_mask,
    output logic [$clog2(NUM_ENTRIES)-1:0] oldest_idx
);
    localparam int IW = $clog2(NUM_ENTRIES);
    localparam logic [IW-1:0] AGE_MAX = IW'(NUM_ENTRIES - 1);

    logic [IW-1:0] age [NUM_ENTRIES];
    logic [IW-1:0] best_age;

    // The strict greater-than comparison keeps the lowest index when ages tie.
    always_comb begin
        oldest_idx = '0;
        best_age   = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (age[i] > best_age) begin
                best_age   = age[i];
                oldest_idx = IW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                age[i] <= IW'(i);
            end
        end else if (touch) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (IW'(i) == touch_idx) begin
                    age[i] <= '0;
                end else if (touch_fill ? valid_mask[i] : (age[i] < age[touch_idx])) begin
                    if (age[i] != AGE_MAX) begin
                        age[i] <= age[i] + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/param_victim_cache.sv
// Fully associative victim cache between L2 and memory.
//
// L2 pushes evicted lines in (evict_*), and probes the cache on an L2 miss
// (lookup_*). A probe hit hands the line back and invalidates it here. When
// the cache is full and the oldest entry is dirty, that entry is written back
// (mem_*) before the new victim takes its slot.
//
// Handshakes: evict_valid and lookup_valid are held by L2 until the matching
// one-cycle pulse (evict_ack / lookup_done) is seen. mem_write is held until
// mem_resp. Requests are sampled only in IDLE.
//
// Ports:
//   clk, rst                              - clock, synchronous active-high reset
//   evict_valid/addr/data/dirty, evict_ack - victim install channel
//   lookup_valid/addr, lookup_done/hit/data/dirty - probe channel
//   mem_write/address/wdata, mem_resp     - writeback channel
//   vc_busy                               - high when the state is not IDLE
//   hit_count, miss_count, wb_count       - 32-bit event counters, present only
//                                           when VC_PERF_CTR_EN is defined
module param_victim_cache
    import lc3b_types::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int LINE_WIDTH  = 128,
    parameter int ADDR_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  evict_valid,
    input  logic [ADDR_WIDTH-1:0] evict_addr,
    input  logic [LINE_WIDTH-1:0] evict_data,
    input  logic                  evict_dirty,
    output logic                  evict_ack,
    input  logic                  lookup_valid,
    input  logic [ADDR_WIDTH-1:0] lookup_addr,
    output logic                  lookup_done,
    output logic                  lookup_hit,
    output logic [LINE_WIDTH-1:0] lookup_data,
    output logic                  lookup_dirty,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic                  mem_resp,
    output logic                  vc_busy
`ifdef VC_PERF_CTR_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count,
    output logic [31:0]           wb_count
`endif
);
    localparam int IW = $clog2(NUM_ENTRIES);

    vc_state_t state, state_next;

    vc_entry_t             flags [NUM_ENTRIES];
    logic [ADDR_WIDTH-1:0] tags  [NUM_ENTRIES];
    logic [LINE_WIDTH-1:0] lines [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] valid_mask;

    logic          probe_hit, ev_match, has_free;
    logic [IW-1:0] probe_idx, ev_match_idx, free_idx, oldest_idx, wb_idx;

    // The victim is captured when a writeback starts, so the install on
    // mem_resp does not depend on L2 keeping its outputs stable.
    logic [ADDR_WIDTH-1:0] held_addr;
    logic [LINE_WIDTH-1:0] held_data;
    logic                  held_dirty;

    logic                  do_lookup, do_install, ins_fill, start_wb;
    logic [IW-1:0]         ins_idx;
    logic [ADDR_WIDTH-1:0] ins_addr;
    logic [LINE_WIDTH-1:0] ins_data;
    logic                  ins_dirty;

    // Scanning downward lets the lowest index win every search.
    always_comb begin
        probe_hit    = 1'b0;
        probe_idx    = '0;
        ev_match     = 1'b0;
        ev_match_idx = '0;
        has_free     = 1'b0;
        free_idx     = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            valid_mask[i] = flags[i].valid;
            if (flags[i].valid && tags[i] == lookup_addr) begin
                probe_hit = 1'b1;
                probe_idx = IW'(i);
            end
            if (flags[i].valid && tags[i] == evict_addr) begin
                ev_match     = 1'b1;
                ev_match_idx = IW'(i);
            end
            if (!flags[i].valid) begin
                has_free = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A victim whose tag is already resident updates that entry in place, so
    // no duplicate tag is ever created. A swap goes ahead only when it cannot
    // duplicate a tag held in some other slot. Otherwise the probe completes
    // first and the eviction retries on the next cycle.
    always_comb begin
        state_next = state;
        do_lookup  = 1'b0;
        do_install = 1'b0;
        start_wb   = 1'b0;
        ins_idx    = '0;
        ins_fill   = 1'b0;
        ins_addr   = evict_addr;
        ins_data   = evict_data;
        ins_dirty  = evict_dirty;
        case (state)
            IDLE: begin
                if (lookup_valid && evict_valid && probe_hit &&
                    (!ev_match || ev_match_idx == probe_idx)) begin
                    do_lookup  = 1'b1;
                    do_install = 1'b1;
                    ins_idx    = probe_idx;
                end else if (lookup_valid) begin
                    do_lookup = 1'b1;
                end else if (evict_valid) begin
                    if (ev_match) begin
                        do_install = 1'b1;
                        ins_idx    = ev_match_idx;
                        ins_dirty  = evict_dirty | flags[ev_match_idx].dirty;
                    end else if (has_free) begin
                        do_install = 1'b1;
                        ins_idx    = free_idx;
                        ins_fill   = 1'b1;
                    end else if (!flags[oldest_idx].dirty) begin
                        do_install = 1'b1;
                        ins_idx    = oldest_idx;
                    end else begin
                        start_wb   = 1'b1;
                        state_next = WRITEBACK;
                    end
                end
            end
            WRITEBACK: begin
                ins_addr  = held_addr;
                ins_data  = held_data;
                ins_dirty = held_dirty;
                if (mem_resp) begin
                    do_install = 1'b1;
                    ins_idx    = wb_idx;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Control and status registers. In a swap the install is assigned after
    // the probe invalidation, so the new line's valid bit wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                flags[i] <= '0;
            end
            evict_ack    <= 1'b0;
            lookup_done  <= 1'b0;
            lookup_hit   <= 1'b0;
            lookup_data  <= '0;
            lookup_dirty <= 1'b0;
            mem_address  <= '0;
            mem_wdata    <= '0;
            wb_idx       <= '0;
            held_addr    <= '0;
            held_data    <= '0;
            held_dirty   <= 1'b0;
        end else begin
            evict_ack   <= do_install;
            lookup_done <= do_lookup;
            if (do_lookup) begin
                lookup_hit   <= probe_hit;
                lookup_data  <= probe_hit ? lines[probe_idx] : '0;
                lookup_dirty <= probe_hit & flags[probe_idx].dirty;
                if (probe_hit) begin
                    flags[probe_idx].valid <= 1'b0;
                end
            end
            if (do_install) begin
                flags[ins_idx] <= '{valid: 1'b1, dirty: ins_dirty};
            end
            if (start_wb) begin
                wb_idx      <= oldest_idx;
                mem_address <= tags[oldest_idx];
                mem_wdata   <= lines[oldest_idx];
                held_addr   <= evict_addr;
                held_data   <= evict_data;
                held_dirty  <= evict_dirty;
            end
        end
    end

    // Tag and data storage needs no reset; the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (do_install) begin
            tags[ins_idx]  <= ins_addr;
            lines[ins_idx] <= ins_data;
        end
    end

    assign mem_write = (state == WRITEBACK);
    assign vc_busy   = (state != IDLE);

    vc_lru #(
        .NUM_ENTRIES(NUM_ENTRIES)
    ) u_lru (
        .clk       (clk),
        .rst       (rst),
        .touch     (do_install),
        .touch_idx (ins_idx),
        .touch_fill(ins_fill),
        .valid_mask(valid_mask),
        .oldest_idx(oldest_idx)
    );

`ifdef VC_PERF_CTR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (do_lookup && probe_hit) begin
                hit_count <= hit_count + 32'd1;
            end
            if (do_lookup && !probe_hit) begin
                miss_count <= miss_count + 32'd1;
            end
            if (state == WRITEBACK && mem_resp) begin
                wb_count <= wb_count + 32'd1;
            end
        end
    end
`endif

endmodule
